// File: rtl/cpu_isa_pkg.sv
// Purpose: shared ISA definitions for the 16-bit core. Holds the opcode/ext
// field codes, the ALU operation codes, the decode FSM state encodings and the
// decoded-bundle payload used by the decoder, ALU and register-file blocks.
package cpu_isa_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned FIELD_W = 4;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned WAIT_W  = 4;

  // Major opcodes with a fixed meaning
  localparam logic [FIELD_W-1:0] OP_REG   = 4'b0000;
  localparam logic [FIELD_W-1:0] OP_MEM   = 4'b0100;
  localparam logic [FIELD_W-1:0] OP_LSH   = 4'b1000;
  localparam logic [FIELD_W-1:0] OP_BCOND = 4'b1100;
  localparam logic [FIELD_W-1:0] OP_LUI   = 4'b1111;

  // ALU selectors: ext field of register forms, op field of immediate forms
  localparam logic [FIELD_W-1:0] EXT_ADD = 4'b0101;
  localparam logic [FIELD_W-1:0] EXT_SUB = 4'b1001;
  localparam logic [FIELD_W-1:0] EXT_CMP = 4'b1011;
  localparam logic [FIELD_W-1:0] EXT_AND = 4'b0001;
  localparam logic [FIELD_W-1:0] EXT_OR  = 4'b0010;
  localparam logic [FIELD_W-1:0] EXT_XOR = 4'b0011;
  localparam logic [FIELD_W-1:0] EXT_MOV = 4'b1101;

  localparam logic [FIELD_W-1:0] EXT_LSH_REG = 4'b0100;
  localparam logic [FIELD_W-1:0] EXT_LSH_IMM = 4'b0000;
  localparam logic [FIELD_W-1:0] EXT_LOAD    = 4'b0000;
  localparam logic [FIELD_W-1:0] EXT_STOR    = 4'b0100;

  localparam logic [FIELD_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [FIELD_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [FIELD_W-1:0] ALU_CMP  = 4'd2;
  localparam logic [FIELD_W-1:0] ALU_AND  = 4'd3;
  localparam logic [FIELD_W-1:0] ALU_OR   = 4'd4;
  localparam logic [FIELD_W-1:0] ALU_XOR  = 4'd5;
  localparam logic [FIELD_W-1:0] ALU_MOV  = 4'd6;
  localparam logic [FIELD_W-1:0] ALU_LSH  = 4'd7;
  localparam logic [FIELD_W-1:0] ALU_LUI  = 4'd8;
  localparam logic [FIELD_W-1:0] ALU_PASS = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_WAIT = 2'd2,
    S_TRAP = 2'd3
  } state_t;

  typedef struct packed {
    logic [FIELD_W-1:0] alu_op;
    logic [FIELD_W-1:0] rdest;
    logic [FIELD_W-1:0] rsrc;
    logic [DATA_W-1:0]  imm;
    logic               use_imm;
    logic               reg_we;
    logic               mem_rd;
    logic               mem_wr;
    logic               branch;
    logic               illegal;
  } dec_bundle_t;

  // Maps an ALU selector code to {hit, alu_op}; hit=0 for unknown codes.
  function automatic logic [FIELD_W:0] alu_lookup(input logic [FIELD_W-1:0] code);
    case (code)
      EXT_ADD: return {1'b1, ALU_ADD};
      EXT_SUB: return {1'b1, ALU_SUB};
      EXT_CMP: return {1'b1, ALU_CMP};
      EXT_AND: return {1'b1, ALU_AND};
      EXT_OR:  return {1'b1, ALU_OR};
      EXT_XOR: return {1'b1, ALU_XOR};
      EXT_MOV: return {1'b1, ALU_MOV};
      default: return {1'b0, ALU_PASS};
    endcase
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Purpose: purely combinational field decoder, 16-bit instruction -> bundle.
// Ports:
//   instruction  in  16  [15:12] op, [11:8] rdest, [7:4] ext, [3:0] rsrc/imm_lo
//   bundle       out     decoded control (dec_bundle_t); unknown encodings
//                        come out as a PASS/no-side-effect bundle with illegal=1
module instr_field_decode
  import cpu_isa_pkg::*;
(
  input  logic [INSTR_W-1:0] instruction,
  output dec_bundle_t        bundle
);

  logic [FIELD_W-1:0] op;
  logic [FIELD_W-1:0] rd;
  logic [FIELD_W-1:0] ext;
  logic [FIELD_W-1:0] lo;
  logic [FIELD_W:0]   reg_form;
  logic [FIELD_W:0]   imm_form;

  assign op  = instruction[15:12];
  assign rd  = instruction[11:8];
  assign ext = instruction[7:4];
  assign lo  = instruction[3:0];

  // Register forms select the ALU op by ext, immediate forms by op itself
  assign reg_form = alu_lookup(ext);
  assign imm_form = alu_lookup(op);

  always_comb begin
    bundle         = '0;
    bundle.alu_op  = ALU_PASS;
    bundle.rdest   = rd;
    bundle.rsrc    = lo;
    bundle.imm     = {{(DATA_W-8){ext[FIELD_W-1]}}, ext, lo};
    bundle.illegal = 1'b1;
    if (op == OP_REG) begin
      if (reg_form[FIELD_W]) begin
        bundle.alu_op  = reg_form[FIELD_W-1:0];
        bundle.reg_we  = (reg_form[FIELD_W-1:0] != ALU_CMP);
        bundle.illegal = 1'b0;
      end
    end else if (imm_form[FIELD_W]) begin
      bundle.alu_op  = imm_form[FIELD_W-1:0];
      bundle.use_imm = 1'b1;
      bundle.reg_we  = (imm_form[FIELD_W-1:0] != ALU_CMP);
      bundle.illegal = 1'b0;
    end else begin
      case (op)
        OP_LSH: begin
          if (ext == EXT_LSH_REG || ext == EXT_LSH_IMM) begin
            bundle.alu_op  = ALU_LSH;
            bundle.use_imm = (ext == EXT_LSH_IMM);
            bundle.reg_we  = 1'b1;
            bundle.illegal = 1'b0;
          end
        end
        OP_MEM: begin
          if (ext == EXT_LOAD) begin
            bundle.mem_rd  = 1'b1;
            bundle.reg_we  = 1'b1;
            bundle.illegal = 1'b0;
          end else if (ext == EXT_STOR) begin
            bundle.mem_wr  = 1'b1;
            bundle.illegal = 1'b0;
          end
        end
        OP_BCOND: begin
          bundle.branch  = 1'b1;
          bundle.illegal = 1'b0;
        end
        OP_LUI: begin
          bundle.alu_op  = ALU_LUI;
          bundle.imm     = {ext, lo, 8'h00};
          bundle.use_imm = 1'b1;
          bundle.reg_we  = 1'b1;
          bundle.illegal = 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_decode_unit.sv
// Purpose: consumer end of the instruction stream. Accepts one instruction per
// valid/ready handshake, registers the decoded bundle for the REG/ALU datapath,
// stalls MEM_WAIT cycles after a LOAD is taken, and counts issued bundles.
// Build option: ILLEGAL_TRAP_EN - illegal encodings lock the block in S_TRAP
// (sticky illegal) instead of issuing a NOP bundle flagged illegal.
// Ports:
//   clock, reset             rising-edge clock, synchronous active-high reset
//   instr_valid/instr_ready  upstream handshake; instruction is the 16-bit word
//   dec_valid/dec_ready      downstream handshake for the decoded bundle
//   alu_op, rdest, rsrc, imm, use_imm, reg_we, mem_rd, mem_wr, branch, illegal
//                            registered bundle fields
//   dec_count                bundles taken by the datapath (wraps)
module instr_decode_unit
  import cpu_isa_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instruction,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [FIELD_W-1:0] alu_op,
  output logic [FIELD_W-1:0] rdest,
  output logic [FIELD_W-1:0] rsrc,
  output logic [DATA_W-1:0]  imm,
  output logic               use_imm,
  output logic               reg_we,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               branch,
  output logic               illegal,
  output logic [CNT_W-1:0]   dec_count
);

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam bit                LOAD_STALL = (MEM_WAIT != 0);
  localparam logic [WAIT_W-1:0] WAIT_INIT  = WAIT_W'(MEM_WAIT);

  state_t             state, state_nxt;
  dec_bundle_t        bundle_q, bundle_nxt, dec_c;
  logic               valid_q, valid_nxt;
  logic [WAIT_W-1:0]  wait_q, wait_nxt;
  logic [CNT_W-1:0]   count_q, count_nxt;
  logic               live_q;
  logic               xfer_in, xfer_out;
  state_t             take_state;
  logic               take_valid;
  dec_bundle_t        take_bundle;

  instr_field_decode u_field_decode (
    .instruction (instruction),
    .bundle      (dec_c)
  );

  // Ready is held low for the first cycle out of reset; a held LOAD blocks
  // the same-edge refill because its release leads into the wait stall.
  always_comb begin
    instr_ready = 1'b0;
    if (live_q) begin
      case (state)
        S_IDLE:  instr_ready = 1'b1;
        S_HOLD:  instr_ready = dec_ready && !(LOAD_STALL && bundle_q.mem_rd);
        default: instr_ready = 1'b0;
      endcase
    end
  end

  assign xfer_in  = instr_valid && instr_ready;
  assign xfer_out = valid_q && dec_ready;

  // Result of accepting the instruction on the input port
  always_comb begin
    take_state  = S_HOLD;
    take_valid  = 1'b1;
    take_bundle = dec_c;
    if (TRAP_EN && dec_c.illegal) begin
      take_state          = S_TRAP;
      take_valid          = 1'b0;
      take_bundle         = bundle_q;
      take_bundle.illegal = 1'b1;
    end
  end

  // Next-state and datapath register updates
  always_comb begin
    state_nxt  = state;
    valid_nxt  = valid_q;
    bundle_nxt = bundle_q;
    wait_nxt   = wait_q;
    count_nxt  = xfer_out ? count_q + CNT_W'(1) : count_q;
    case (state)
      S_IDLE: begin
        if (xfer_in) begin
          state_nxt  = take_state;
          valid_nxt  = take_valid;
          bundle_nxt = take_bundle;
        end
      end
      S_HOLD: begin
        if (xfer_out) begin
          if (LOAD_STALL && bundle_q.mem_rd) begin
            state_nxt          = S_WAIT;
            valid_nxt          = 1'b0;
            wait_nxt           = WAIT_INIT;
            bundle_nxt.illegal = 1'b0;
          end else if (xfer_in) begin
            state_nxt  = take_state;
            valid_nxt  = take_valid;
            bundle_nxt = take_bundle;
          end else begin
            state_nxt          = S_IDLE;
            valid_nxt          = 1'b0;
            bundle_nxt.illegal = 1'b0;
          end
        end
      end
      S_WAIT: begin
        valid_nxt = 1'b0;
        wait_nxt  = (wait_q != '0) ? wait_q - WAIT_W'(1) : '0;
        if (wait_q <= WAIT_W'(1)) begin
          state_nxt = S_IDLE;
        end
      end
      S_TRAP: begin
        valid_nxt          = 1'b0;
        bundle_nxt.illegal = 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      bundle_q <= '0;
      valid_q  <= 1'b0;
      wait_q   <= '0;
      count_q  <= '0;
      live_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      bundle_q <= bundle_nxt;
      valid_q  <= valid_nxt;
      wait_q   <= wait_nxt;
      count_q  <= count_nxt;
      live_q   <= 1'b1;
    end
  end

  assign dec_valid = valid_q;
  assign alu_op    = bundle_q.alu_op;
  assign rdest     = bundle_q.rdest;
  assign rsrc      = bundle_q.rsrc;
  assign imm       = bundle_q.imm;
  assign use_imm   = bundle_q.use_imm;
  assign reg_we    = bundle_q.reg_we;
  assign mem_rd    = bundle_q.mem_rd;
  assign mem_wr    = bundle_q.mem_wr;
  assign branch    = bundle_q.branch;
  assign illegal   = bundle_q.illegal;
  assign dec_count = count_q;

endmodule

// File: tb/tb_instr_decode_unit.sv
// Scoreboard bench for instr_decode_unit: accepted instructions push their
// reference decode into a queue; a monitor pops and compares on each release.
module tb_instr_decode_unit;
  import cpu_isa_pkg::*;

  localparam int unsigned MW = 2;
  localparam int unsigned CW = 4;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // ISA table: selector code -> ALU op
  localparam logic [3:0] SEL_TAB [7] = '{4'b0101, 4'b1001, 4'b1011, 4'b0001, 4'b0010, 4'b0011, 4'b1101};
  localparam logic [3:0] ALU_TAB [7] = '{ALU_ADD, ALU_SUB, ALU_CMP, ALU_AND, ALU_OR, ALU_XOR, ALU_MOV};

  logic          clock = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic          instr_ready;
  logic [15:0]   instruction;
  logic          dec_valid;
  logic          dec_ready;
  logic [3:0]    alu_op, rdest, rsrc;
  logic [15:0]   imm;
  logic          use_imm, reg_we, mem_rd, mem_wr, branch, illegal;
  logic [CW-1:0] dec_count;
  dec_bundle_t   act_b;

  int          checks   = 0;
  int          failures = 0;
  dec_bundle_t expq[$];
  logic [CW-1:0] exp_cnt = '0;
  bit          mon_en = 1'b0;
  bit          rand_ready = 1'b0;
  bit          prev_bp = 1'b0;
  bit          chk_rdy = 1'b0;
  int          stall_left = 0;

  always #5 clock = ~clock;

  instr_decode_unit #(.MEM_WAIT(MW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .alu_op(alu_op), .rdest(rdest), .rsrc(rsrc), .imm(imm), .use_imm(use_imm),
    .reg_we(reg_we), .mem_rd(mem_rd), .mem_wr(mem_wr), .branch(branch),
    .illegal(illegal), .dec_count(dec_count)
  );

  assign act_b = {alu_op, rdest, rsrc, imm, use_imm, reg_we, mem_rd, mem_wr, branch, illegal};

  // Reference decode straight from the instruction-set table
  function automatic dec_bundle_t model(input logic [15:0] ins);
    dec_bundle_t m;
    logic [3:0] op, ex;
    int fe, fo;
    op = ins[15:12];
    ex = ins[7:4];
    fe = -1;
    fo = -1;
    for (int i = 0; i < 7; i++) begin
      if (SEL_TAB[i] == ex) fe = i;
      if (SEL_TAB[i] == op) fo = i;
    end
    m         = '0;
    m.alu_op  = ALU_PASS;
    m.rdest   = ins[11:8];
    m.rsrc    = ins[3:0];
    m.imm     = {{8{ins[7]}}, ins[7:0]};
    m.illegal = 1'b1;
    if (op == 4'h0 && fe >= 0) begin
      m.alu_op = ALU_TAB[fe]; m.reg_we = (ALU_TAB[fe] != ALU_CMP); m.illegal = 1'b0;
    end else if (fo >= 0) begin
      m.alu_op = ALU_TAB[fo]; m.reg_we = (ALU_TAB[fo] != ALU_CMP); m.use_imm = 1'b1; m.illegal = 1'b0;
    end else if (op == 4'h8 && (ex == 4'h4 || ex == 4'h0)) begin
      m.alu_op = ALU_LSH; m.use_imm = (ex == 4'h0); m.reg_we = 1'b1; m.illegal = 1'b0;
    end else if (op == 4'h4 && ex == 4'h0) begin
      m.mem_rd = 1'b1; m.reg_we = 1'b1; m.illegal = 1'b0;
    end else if (op == 4'h4 && ex == 4'h4) begin
      m.mem_wr = 1'b1; m.illegal = 1'b0;
    end else if (op == 4'hC) begin
      m.branch = 1'b1; m.illegal = 1'b0;
    end else if (op == 4'hF) begin
      m.alu_op = ALU_LUI; m.imm = {ins[7:0], 8'h00}; m.use_imm = 1'b1; m.reg_we = 1'b1; m.illegal = 1'b0;
    end
    return m;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Offer one instruction; returns at the negedge after the accepting edge
  task automatic send(input logic [15:0] ins, input int limit, input bit must_take, output int waited);
    dec_bundle_t m;
    m = model(ins);
    waited = 0;
    instr_valid = 1'b1;
    instruction = ins;
    #1;
    while (!instr_ready && waited < limit) begin
      @(negedge clock);
      #1;
      waited++;
    end
    if (instr_ready) begin
      if (!(TRAP && m.illegal)) expq.push_back(m);
      @(negedge clock);
    end else if (must_take) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: instruction %h not taken within %0d cycles", ins, limit);
    end
    instr_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mon_en = 1'b0;
    instr_valid = 1'b0;
    @(posedge clock);
    #1;
    check("rst_valid", 64'(dec_valid), 64'(0));
    check("rst_count", 64'(dec_count), 64'(0));
    check("rst_bundle", 64'(act_b), 64'(0));
    check("rst_ready", 64'(instr_ready), 64'(0));
    expq.delete();
    exp_cnt = '0;
    stall_left = 0;
    chk_rdy = 1'b0;
    prev_bp = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("ready_after_rst", 64'(instr_ready), 64'(1));
    @(negedge clock);
    mon_en = 1'b1;
  endtask

  always @(negedge clock) begin
    if (rand_ready) dec_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: samples between edges; a release is what the next edge performs
  always @(negedge clock) begin
    dec_bundle_t e;
    #2;
    if (mon_en) begin
      if (stall_left > 0) begin
        check("stall_ready", 64'(instr_ready), 64'(0));
        check("stall_valid", 64'(dec_valid), 64'(0));
        stall_left--;
        if (stall_left == 0) chk_rdy = 1'b1;
      end else if (chk_rdy) begin
        check("post_stall_ready", 64'(instr_ready), 64'(1));
        chk_rdy = 1'b0;
      end
      if (prev_bp) check("held_valid", 64'(dec_valid), 64'(1));
      if (dec_valid && !dec_ready) begin
        check("held_ready", 64'(instr_ready), 64'(0));
        if (expq.size() > 0) check("held_bundle", 64'(act_b), 64'(expq[0]));
      end
      prev_bp = dec_valid && !dec_ready;
      if (dec_valid && dec_ready) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_bundle: got %0h with nothing expected", act_b);
        end else begin
          e = expq.pop_front();
          check("bundle", 64'(act_b), 64'(e));
          check("dec_count", 64'(dec_count), 64'(exp_cnt));
          exp_cnt = exp_cnt + 1'b1;
          if (e.mem_rd && MW > 0) stall_left = MW;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [15:0] ins;
    dec_bundle_t m;
    reset = 1'b1;
    instr_valid = 1'b0;
    instruction = '0;
    dec_ready = 1'b0;
    tick();
    do_reset();

    // ADD r3,r2
    dec_ready = 1'b1;
    send(16'h0352, 4, 1'b1, w);
    #1 check("add_valid", 64'(dec_valid), 64'(1));
    tick();
    #1 check("add_count", 64'(dec_count), 64'(1));
    tick();

    // Back-pressure on ADDI r1,-1, then same-edge release and accept
    dec_ready = 1'b0;
    send(16'h51FF, 4, 1'b1, w);
    repeat (3) begin
      #1 check("bp_imm", 64'(imm), 64'(16'hFFFF));
      tick();
    end
    dec_ready = 1'b1;
    send(16'h0361, 4, 1'b1, w);
    check("same_edge_accept", 64'(w), 64'(0));
    tick();

    // LOAD stall
    send(16'h4502, 8, 1'b1, w);
    send(16'h0361, 8, 1'b1, w);
    repeat (2) tick();

    // Illegal encoding
    send(16'h0F77, 4, 1'b1, w);
    if (TRAP) begin
      instr_valid = 1'b1;
      instruction = 16'h0352;
      repeat (4) begin
        #1;
        check("trap_illegal", 64'(illegal), 64'(1));
        check("trap_ready", 64'(instr_ready), 64'(0));
        check("trap_valid", 64'(dec_valid), 64'(0));
        tick();
      end
      do_reset();
      dec_ready = 1'b1;
      send(16'h0352, 4, 1'b1, w);
      repeat (2) tick();
    end else begin
      send(16'h0352, 4, 1'b1, w);
      tick();
      #1 check("illegal_cleared", 64'(illegal), 64'(0));
      tick();
    end

    // Counter wrap: 16 handshakes from reset
    do_reset();
    dec_ready = 1'b1;
    repeat (16) send(16'h0352, 4, 1'b1, w);
    tick();
    #1 check("wrap_count", 64'(dec_count), 64'(0));
    tick();

    // Reset while holding a bundle
    repeat (3) send(16'h1234, 4, 1'b1, w);
    tick();
    dec_ready = 1'b0;
    send(16'h0352, 4, 1'b1, w);
    tick();
    do_reset();

    // Randomized traffic with random back-pressure and gaps
    rand_ready = 1'b1;
    repeat (300) begin
      do begin
        ins = 16'($urandom);
        m = model(ins);
      end while (TRAP && m.illegal);
      send(ins, 60, 1'b1, w);
      if ($urandom_range(0, 3) == 0) begin
        instruction = 16'($urandom);
        repeat ($urandom_range(1, 3)) tick();
      end
    end
    rand_ready = 1'b0;
    tick();
    dec_ready = 1'b1;
    repeat (MW + 6) tick();
    check("drain_empty", 64'(expq.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
